// File: rtl/io_sink_uart_if.sv
// CPU log-port bus of io_sink_uart: write strobe/data, overflow clear, and the
// serial line plus status it returns.
interface io_sink_uart_if;
   logic        io_write;
   logic [63:0] io_data;
   logic        ovf_clr;
   logic        tx;
   logic        busy;
   logic        fifo_full;
   logic [4:0]  fifo_count;
   logic        overflow;

   modport master (
      output io_write, io_data, ovf_clr,
      input  tx, busy, fifo_full, fifo_count, overflow
   );

   modport slave (
      input  io_write, io_data, ovf_clr,
      output tx, busy, fifo_full, fifo_count, overflow
   );
endinterface

// File: rtl/io_sink_uart.sv
// Log-port sink: buffers 64-bit words and sends each as 8 UART frames, LSB byte first.
// Define IO_SINK_UART_PARITY_EN to add an even-parity bit per frame (8E1 instead of 8N1).
module io_sink_uart #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input logic           clk,
   input logic           rst_n,
   io_sink_uart_if.slave bus
);
   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [4:0]  DEPTH5   = 5'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef IO_SINK_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   logic [63:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    count;
   logic          full, pop, push, drop;
   logic          overflow_q;

   state_t        state, state_nxt;
   logic [15:0]   baud_cnt;
   logic          bit_done;
   logic [2:0]    bit_idx, byte_idx;
   logic [63:0]   shreg;
   logic          tx_q, tx_nxt;

   // A pop frees a slot on the same edge, so a write to a full FIFO still lands then.
   always_comb begin
      full = (count == DEPTH5);
      pop  = (state == IDLE) && (count != 5'd0);
      push = bus.io_write && (!full || pop);
      drop = bus.io_write && !push;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= 5'd0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
         if (drop)             overflow_q <= 1'b1;
         else if (bus.ovf_clr) overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.io_data;
   end

   assign bit_done = (baud_cnt == BIT_LAST);

   always_comb begin
      state_nxt = state;
      tx_nxt    = 1'b1;
      case (state)
         IDLE:  if (pop) state_nxt = START;
         START: begin
            tx_nxt = 1'b0;
            if (bit_done) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shreg[bit_idx];
`ifdef IO_SINK_UART_PARITY_EN
            if (bit_done && bit_idx == 3'd7) state_nxt = PARITY;
         end
         PARITY: begin
            tx_nxt = ^shreg[7:0];
            if (bit_done) state_nxt = STOP;
`else
            if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
`endif
         end
         STOP:  if (bit_done) state_nxt = (byte_idx == 3'd7) ? IDLE : START;
         default: state_nxt = IDLE;
      endcase
   end

   // tx is registered from the current state, so the line trails the FSM by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx_q     <= 1'b1;
         baud_cnt <= 16'd0;
         bit_idx  <= 3'd0;
         byte_idx <= 3'd0;
         shreg    <= 64'd0;
      end else begin
         state    <= state_nxt;
         tx_q     <= tx_nxt;
         baud_cnt <= (state == IDLE || bit_done) ? 16'd0 : baud_cnt + 16'd1;
         if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= 3'd0;
         end
         if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;
         if (state == STOP && bit_done) begin
            byte_idx <= byte_idx + 3'd1;
            shreg    <= {8'h00, shreg[63:8]};
         end
      end
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = (state != IDLE);
   assign bus.fifo_full  = full;
   assign bus.fifo_count = count;
   assign bus.overflow   = overflow_q;
endmodule
